buzzer_sequencer_mu0: RTL



---
 rtl/buzzer_sequencer_mu0.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/buzzer_sequencer_mu0.sv
// buzzer_sequencer_mu0: queues buzzer command words and writes them to 12'hFFD
// one at a time, waiting for each note plus a silent gap. Optional: BUZSEQ_LOOP_EN.
module buzzer_sequencer_mu0 #(
    parameter int DEPTH         = 8,
    parameter int GAP_CYCLES    = 250000,
    parameter int START_TIMEOUT = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [15:0]              in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic                     buzzer_busy,
    output logic                     bus_req,
    input  logic                     bus_gnt,
    output logic [11:0]              bus_addr,
    output logic [15:0]              bus_wdata,
    output logic [$clog2(DEPTH):0]   count,
`ifdef BUZSEQ_LOOP_EN
    input  logic                     loop,
`endif
    output logic                     active,
    output logic                     timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam int TW = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(START_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WSTART, S_WDONE, S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [15:0]     wdata_q, wdata_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [TW-1:0]   to_q, to_d;
    logic            err_q, err_d;
    logic            loop_on, push, grant, recirc, mem_we;
    logic [15:0]     mem_wd;

`ifdef BUZSEQ_LOOP_EN
    assign loop_on = loop;
`else
    assign loop_on = 1'b0;
`endif

    assign in_ready = (count_q != CW'(DEPTH)) & ~loop_on;
    assign push     = in_valid & in_ready & ~flush;
    assign grant    = (state_q == S_ISSUE) & bus_gnt;
    assign recirc   = grant & loop_on;
    assign mem_we   = push | recirc;
    assign mem_wd   = push ? in_data : wdata_q;

    // FIFO storage; recirculation reuses the tail write port
    always_ff @(posedge Clk) begin
        if (mem_we)
            mem[wr_ptr_q] <= mem_wd;
    end

    // FIFO pointers and occupancy; a recirculated word keeps count unchanged
    always_ff @(posedge Clk) begin
        if (Reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (mem_we)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (grant)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !grant)
                count_q <= count_q + CW'(1);
            else if (!push && grant && !recirc)
                count_q <= count_q - CW'(1);
        end
    end

    // Sequencer state and datapath registers; flush aborts but keeps wdata
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            wdata_q <= '0;
            gap_q   <= '0;
            to_q    <= '0;
            err_q   <= 1'b0;
        end else if (flush) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            to_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wdata_q <= wdata_d;
            gap_q   <= gap_d;
            to_q    <= to_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: issue, wait for note start/end, then silent gap
    always_comb begin
        state_d = state_q;
        wdata_d = wdata_q;
        gap_d   = gap_q;
        to_d    = to_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    wdata_d = mem[rd_ptr_q];
                    state_d = S_ISSUE;
                end else if (push) begin
                    wdata_d = in_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus_gnt) begin
                    if (wdata_q[15] && (wdata_q[11:8] != 4'd0)) begin
                        to_d    = '0;
                        state_d = S_WSTART;
                    end else begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_WSTART: begin
                if (buzzer_busy) begin
                    state_d = S_WDONE;
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    gap_d   = '0;
                    state_d = S_GAP;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            S_WDONE: begin
                if (!buzzer_busy) begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST)
                    state_d = S_IDLE;
                else
                    gap_d = gap_q + GW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state and registers
    always_comb begin
        bus_req     = (state_q == S_ISSUE);
        active      = (state_q != S_IDLE);
        bus_addr    = 12'hFFD;
        bus_wdata   = wdata_q;
        count       = count_q;
        timeout_err = err_q;
    end

endmodule
